ram_iniciador: RTL and testbench

- Synchronous initiator/controller that drives an 11-word × 8-bit asynchronous RAM port.
- The RAM port is level-sensitive: EN=1 writes, EN=0 reads combinationally.
- Accepts commands over a valid/ready interface: single read, single write, block fill, block checksum.
- Sequences safe address/data/strobe timing on the RAM and returns one response per command.

---
 rtl/ram_iniciador_pkg.sv | 44 ++++
 rtl/ram_iniciador_if.sv | 34 +++
 rtl/ram_iniciador_dirgen.sv | 33 +++
 rtl/ram_iniciador.sv | 179 +++++++++++++++++
 tb/tb_ram_iniciador.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_iniciador_pkg.sv
// Shared definitions for the ram_iniciador RAM initiator: command op codes,
// FSM state encodings and the default RAM depth.
// Optional feature macro: RAMINI_READBACK_EN adds the VERIFY state.
package ram_iniciador_pkg;

    localparam int DEPTH_DEFAULT = 11;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;
    localparam logic [1:0] OP_SUM  = 2'b11;

`ifdef RAMINI_READBACK_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD        = 3'd1,
        ST_WR_SETUP  = 3'd2,
        ST_WR_STROBE = 3'd3,
        ST_WR_HOLD   = 3'd4,
        ST_DONE      = 3'd5,
        ST_VERIFY    = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD        = 3'd1,
        ST_WR_SETUP  = 3'd2,
        ST_WR_STROBE = 3'd3,
        ST_WR_HOLD   = 3'd4,
        ST_DONE      = 3'd5
    } state_t;
`endif

    // Fill and checksum walk a range of words; read and write touch one.
    function automatic logic is_block(input logic [1:0] op);
        return op[1];
    endfunction

    // Read and checksum only sample the RAM; write and fill strobe it.
    function automatic logic is_write(input logic [1:0] op);
        return (op == OP_WR) || (op == OP_FILL);
    endfunction

endpackage

// File: rtl/ram_iniciador_if.sv
// Command/response handshake plus the asynchronous RAM port of ram_iniciador.
// slave: the controller's view; master: the command source / RAM side.
interface ram_iniciador_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_dir;
    logic [DW-1:0] cmd_dato;
    logic [AW-1:0] cmd_len;

    logic          rsp_valid;
    logic [DW-1:0] rsp_dato;
    logic          rsp_err;

    logic [AW-1:0] mem_dir;
    logic [DW-1:0] mem_dato_e;
    logic          mem_en;
    logic [DW-1:0] mem_dato_s;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_dato, cmd_len, mem_dato_s,
        output cmd_ready, rsp_valid, rsp_dato, rsp_err,
        output mem_dir, mem_dato_e, mem_en
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_dato, cmd_len, mem_dato_s,
        input  cmd_ready, rsp_valid, rsp_dato, rsp_err,
        input  mem_dir, mem_dato_e, mem_en
    );
endinterface

// File: rtl/ram_iniciador_dirgen.sv
// Address/count generator for ram_iniciador: loads a base address and word
// count, then advances one word per step and flags the final word.
module ram_ini_dirgen #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] count,
    input  logic          step,
    output logic [AW-1:0] dir,
    output logic          last
);
    logic [AW-1:0] remaining;

    // Load wins over step; the address is the RAM address register itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir       <= '0;
            remaining <= '0;
        end else if (load) begin
            dir       <= base;
            remaining <= count;
        end else if (step) begin
            dir       <= dir + AW'(1);
            remaining <= remaining - AW'(1);
        end
    end

    assign last = (remaining == AW'(1));

endmodule

// File: rtl/ram_iniciador.sv
// ram_iniciador: command-driven initiator for an asynchronous 8-bit RAM port.
// Optional feature macro: RAMINI_READBACK_EN (verify every written word).
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_IDLE      | cmd_ready high, RAM address/data held
//   ST_RD        | address driven, read data sampled at end of cycle
//   ST_WR_SETUP  | address/data driven, strobe low
//   ST_WR_STROBE | write strobe high for this single cycle
//   ST_WR_HOLD   | strobe low, address/data still held
//   ST_VERIFY    | (readback only) same address re-read and compared
//   ST_DONE      | one-cycle response pulse
module ram_iniciador
    import ram_iniciador_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    ram_iniciador_if.slave  bus
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state;
    logic [1:0]    op;
    logic [DW-1:0] sum;
    logic [DW-1:0] sum_next;
    logic [AW:0]   end_dir;
    logic          rng_err;
    logic          len_zero;
    logic          accept;
    logic          load;
    logic          step;
    logic          last;
    logic [AW-1:0] dir;
`ifdef RAMINI_READBACK_EN
    logic          err_sticky;
    logic          mismatch;
`endif

    // Range check at AW+1 bits so dir+len cannot wrap into a false pass.
    assign end_dir  = {1'b0, bus.cmd_dir} + {1'b0, bus.cmd_len};
    assign rng_err  = is_block(bus.cmd_op) ? (end_dir > DEPTH_W)
                                           : ({1'b0, bus.cmd_dir} >= DEPTH_W);
    assign len_zero = is_block(bus.cmd_op) && (bus.cmd_len == '0);
    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign load     = accept && !rng_err && !len_zero;
    assign sum_next = sum + bus.mem_dato_s;

    // Advance to the next word at the end of each word's final cycle.
`ifdef RAMINI_READBACK_EN
    assign mismatch = (bus.mem_dato_s != bus.mem_dato_e);
    assign step = !last && ((state == ST_VERIFY) ||
                            ((state == ST_RD) && (op == OP_SUM)));
`else
    assign step = !last && ((state == ST_WR_HOLD) ||
                            ((state == ST_RD) && (op == OP_SUM)));
`endif

    ram_ini_dirgen #(.AW(AW)) u_dirgen (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .base  (bus.cmd_dir),
        .count (is_block(bus.cmd_op) ? bus.cmd_len : AW'(1)),
        .step  (step),
        .dir   (dir),
        .last  (last)
    );

    assign bus.mem_dir = dir;

    // Command sequencer with registered strobe, ready and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            op             <= OP_RD;
            sum            <= '0;
            bus.cmd_ready  <= 1'b1;
            bus.mem_en     <= 1'b0;
            bus.mem_dato_e <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_dato   <= '0;
            bus.rsp_err    <= 1'b0;
`ifdef RAMINI_READBACK_EN
            err_sticky     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op            <= bus.cmd_op;
                        sum           <= '0;
                        bus.cmd_ready <= 1'b0;
`ifdef RAMINI_READBACK_EN
                        err_sticky    <= 1'b0;
`endif
                        if (rng_err || len_zero) begin
                            state         <= ST_DONE;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_dato  <= '0;
                            bus.rsp_err   <= rng_err;
                        end else if (is_write(bus.cmd_op)) begin
                            state          <= ST_WR_SETUP;
                            bus.mem_dato_e <= bus.cmd_dato;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (op == OP_RD) begin
                        state         <= ST_DONE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_dato  <= bus.mem_dato_s;
                        bus.rsp_err   <= 1'b0;
                    end else begin
                        sum <= sum_next;
                        if (last) begin
                            state         <= ST_DONE;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_dato  <= sum_next;
                            bus.rsp_err   <= 1'b0;
                        end
                    end
                end
                ST_WR_SETUP: begin
                    state      <= ST_WR_STROBE;
                    bus.mem_en <= 1'b1;
                end
                ST_WR_STROBE: begin
                    state      <= ST_WR_HOLD;
                    bus.mem_en <= 1'b0;
                end
                ST_WR_HOLD: begin
`ifdef RAMINI_READBACK_EN
                    state <= ST_VERIFY;
`else
                    if (last) begin
                        state         <= ST_DONE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_dato  <= '0;
                        bus.rsp_err   <= 1'b0;
                    end else begin
                        state <= ST_WR_SETUP;
                    end
`endif
                end
`ifdef RAMINI_READBACK_EN
                ST_VERIFY: begin
                    err_sticky <= err_sticky | mismatch;
                    if (last) begin
                        state         <= ST_DONE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_dato  <= '0;
                        bus.rsp_err   <= err_sticky | mismatch;
                    end else begin
                        state <= ST_WR_SETUP;
                    end
                end
`endif
                ST_DONE: begin
                    state         <= ST_IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.mem_en    <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_iniciador.sv
// Self-checking bench for ram_iniciador with an 11-word RAM model and a
// word-level reference model. Build with RAMINI_READBACK_EN to cover verify.
module tb_ram_iniciador;
    localparam int MAXC = 60;
`ifdef RAMINI_READBACK_EN
    localparam int WL = 4;
`else
    localparam int WL = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ram_iniciador_if #(.AW(8), .DW(8)) bus ();

    ram_iniciador dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram    [0:10];
    logic [7:0] shadow [0:10];
    logic       preload = 1'b1;
    logic       corrupt = 1'b0;

    function automatic logic [7:0] init_val(input int i);
        case (i)
            0: return 8'd90;   1: return 8'd80;   2: return 8'd70;
            3: return 8'd60;   4: return 8'd50;   5: return 8'd40;
            6: return 8'd30;   7: return 8'd20;   8: return 8'd10;
            9: return 8'd100;  default: return 8'd101;
        endcase
    endfunction

    // RAM model: latches write data mid-strobe (falling edge of clk).
    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 11; i++) ram[i] = init_val(i);
        end else if (bus.mem_en && bus.mem_dir < 8'd11) begin
            ram[bus.mem_dir[3:0]] = bus.mem_dato_e;
        end
    end

    assign bus.mem_dato_s = (bus.mem_dir < 8'd11)
        ? (ram[bus.mem_dir[3:0]] ^ ((corrupt && bus.mem_dir == 8'd2) ? 8'hFF : 8'h00))
        : 8'h00;

    int         obs_lat, obs_en_cnt;
    logic [7:0] obs_dato;
    logic       obs_err, obs_after;
    logic [7:0] obs_dir [0:MAXC];
    logic       obs_en  [0:MAXC];

    // Reference model: word-level effect, response and latency of one command.
    task automatic model_cmd(input int op, input int dir, input int dato, input int len,
                             output int e_dato, output int e_err, output int e_lat,
                             output int e_en);
        bit single = (op < 2);
        int s;
        e_dato = 0; e_err = 0; e_lat = 1; e_en = 0;
        if (single ? (dir >= 11) : (dir + len > 11)) begin
            e_err = 1;
        end else if (!single && len == 0) begin
            e_lat = 1;
        end else begin
            case (op)
                0: begin e_dato = shadow[dir]; e_lat = 2; end
                1: begin shadow[dir] = dato[7:0]; e_lat = WL + 1; e_en = 1; end
                2: begin
                    for (int i = 0; i < len; i++) shadow[dir + i] = dato[7:0];
                    e_lat = WL * len + 1; e_en = len;
                end
                default: begin
                    s = 0;
                    for (int i = 0; i < len; i++) s += shadow[dir + i];
                    e_dato = s % 256; e_lat = len + 1;
                end
            endcase
        end
    endtask

    // Issues one command and records what the DUT does, cycle by cycle.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] dir,
                          input logic [7:0] dato, input logic [7:0] len);
        int waited = 0;
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_dir = dir; bus.cmd_dato = dato; bus.cmd_len = len;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        obs_lat = -1; obs_en_cnt = 0; obs_after = 1'b1; obs_dato = 8'hXX; obs_err = 1'bx;
        for (int k = 1; k < MAXC; k++) begin
            obs_dir[k] = bus.mem_dir;
            obs_en[k]  = bus.mem_en;
            if (bus.mem_en) obs_en_cnt++;
            if (obs_lat > 0) begin
                obs_after = bus.rsp_valid;
                break;
            end
            if (bus.rsp_valid) begin
                obs_lat = k; obs_dato = bus.rsp_dato; obs_err = bus.rsp_err;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_dir = '0;
        bus.cmd_dato = '0; bus.cmd_len = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        for (int i = 0; i < 11; i++) shadow[i] = init_val(i);
        checks++;
        if (bus.mem_en !== 1'b0 || bus.mem_dir !== 8'd0 || bus.mem_dato_e !== 8'd0) begin
            errors++;
            $display("FAIL reset_mem: en=%b dir=%0d dato_e=%0d, required 0/0/0",
                     bus.mem_en, bus.mem_dir, bus.mem_dato_e);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_dato !== 8'd0 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b dato=%0d err=%b, required 0/0/0",
                     bus.rsp_valid, bus.rsp_dato, bus.rsp_err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_read;
        int ed, ee, el, en;
        model_cmd(0, 3, 0, 0, ed, ee, el, en);
        do_cmd(2'b00, 8'd3, 8'd0, 8'd0);
        checks++;
        if (obs_dato !== 8'd60 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL read3_data: got dato=%0d err=%b, required 60/0", obs_dato, obs_err);
        end
        checks++;
        if (obs_lat !== el || obs_after !== 1'b0) begin
            errors++;
            $display("FAIL read3_latency: got N+%0d pulse_after=%b, required N+%0d/0",
                     obs_lat, obs_after, el);
        end
        checks++;
        if (obs_en_cnt !== 0) begin
            errors++;
            $display("FAIL read3_no_strobe: mem_en high %0d cycles, required 0", obs_en_cnt);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_dato !== 8'd60) begin
            errors++;
            $display("FAIL read3_hold: rsp_dato=%0d, required 60", bus.rsp_dato);
        end
    endtask

    task automatic test_checksum;
        int ed, ee, el, en;
        model_cmd(3, 0, 0, 11, ed, ee, el, en);
        do_cmd(2'b11, 8'd0, 8'd0, 8'd11);
        checks++;
        if (obs_dato !== 8'd139 || obs_err !== 1'b0 || obs_lat !== el) begin
            errors++;
            $display("FAIL sum_all: got dato=%0d err=%b lat=%0d, required 139/0/%0d",
                     obs_dato, obs_err, obs_lat, el);
        end
        model_cmd(2, 8, 7, 3, ed, ee, el, en);
        do_cmd(2'b10, 8'd8, 8'd7, 8'd3);
        checks++;
        if (obs_lat !== el || obs_en_cnt !== 3 || obs_err !== 1'b0 || obs_dato !== 8'd0) begin
            errors++;
            $display("FAIL fill8: got lat=%0d strobes=%0d err=%b dato=%0d, required %0d/3/0/0",
                     obs_lat, obs_en_cnt, obs_err, obs_dato, el);
        end
        model_cmd(3, 8, 0, 3, ed, ee, el, en);
        do_cmd(2'b11, 8'd8, 8'd0, 8'd3);
        checks++;
        if (obs_dato !== 8'd21 || obs_lat !== el) begin
            errors++;
            $display("FAIL sum_fill8: got dato=%0d lat=%0d, required 21/%0d",
                     obs_dato, obs_lat, el);
        end
    endtask

    task automatic test_write;
        int ed, ee, el, en;
        model_cmd(1, 5, 8'hAA, 0, ed, ee, el, en);
        do_cmd(2'b01, 8'd5, 8'hAA, 8'd0);
        checks++;
        if (obs_lat !== el || obs_err !== 1'b0 || obs_dato !== 8'd0) begin
            errors++;
            $display("FAIL write5_rsp: got lat=%0d err=%b dato=%0d, required %0d/0/0",
                     obs_lat, obs_err, obs_dato, el);
        end
        checks++;
        if (obs_en_cnt !== 1 || obs_en[2] !== 1'b1) begin
            errors++;
            $display("FAIL write5_strobe: high %0d cycles, at N+2=%b, required 1/1",
                     obs_en_cnt, obs_en[2]);
        end
        checks++;
        if (obs_dir[1] !== 8'd5 || obs_dir[2] !== 8'd5 || obs_dir[3] !== 8'd5) begin
            errors++;
            $display("FAIL write5_dir: got %0d,%0d,%0d, required 5,5,5",
                     obs_dir[1], obs_dir[2], obs_dir[3]);
        end
        model_cmd(0, 5, 0, 0, ed, ee, el, en);
        do_cmd(2'b00, 8'd5, 8'd0, 8'd0);
        checks++;
        if (obs_dato !== 8'hAA) begin
            errors++;
            $display("FAIL write5_readback: got %0h, required aa", obs_dato);
        end
    endtask

    task automatic test_range;
        int ed, ee, el, en;
        logic [1:0] ops  [0:2];
        logic [7:0] dirs [0:2];
        logic [7:0] lens [0:2];
        ops[0] = 2'b00; dirs[0] = 8'd11;  lens[0] = 8'd0;
        ops[1] = 2'b10; dirs[1] = 8'd9;   lens[1] = 8'd3;
        ops[2] = 2'b11; dirs[2] = 8'd255; lens[2] = 8'd255;
        for (int i = 0; i < 3; i++) begin
            model_cmd(int'(ops[i]), int'(dirs[i]), 8'h5A, int'(lens[i]), ed, ee, el, en);
            do_cmd(ops[i], dirs[i], 8'h5A, lens[i]);
            checks++;
            if (obs_err !== 1'b1 || obs_dato !== 8'd0 || obs_lat !== 1 || obs_en_cnt !== 0) begin
                errors++;
                $display("FAIL range_%0d: got err=%b dato=%0d lat=%0d strobes=%0d, required 1/0/1/0",
                         i, obs_err, obs_dato, obs_lat, obs_en_cnt);
            end
        end
        do_cmd(2'b10, 8'd4, 8'h33, 8'd0);
        checks++;
        if (obs_err !== 1'b0 || obs_dato !== 8'd0 || obs_lat !== 1 || obs_en_cnt !== 0) begin
            errors++;
            $display("FAIL len0: got err=%b dato=%0d lat=%0d strobes=%0d, required 0/0/1/0",
                     obs_err, obs_dato, obs_lat, obs_en_cnt);
        end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (ram[i] !== shadow[i]) begin
                errors++;
                $display("FAIL range_ram[%0d]: got %0d, required %0d", i, ram[i], shadow[i]);
            end
        end
    endtask

    task automatic test_reset_abort;
        int ed, ee, el, en;
        logic saw_valid = 1'b0;
        @(negedge clk);
        bus.cmd_op = 2'b10; bus.cmd_dir = 8'd0; bus.cmd_dato = 8'h55; bus.cmd_len = 8'd3;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.mem_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_strobe_seen: mem_en=%b at N+2, required 1", bus.mem_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_en_drop: mem_en=%b during reset, required 0", bus.mem_en);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) saw_valid = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_rsp: rsp_valid seen=%b ready=%b, required 0/1",
                     saw_valid, bus.cmd_ready);
        end
        for (int i = 0; i < 2; i++) begin
            model_cmd(0, i, 0, 0, ed, ee, el, en);
            do_cmd(2'b00, 8'(i), 8'd0, 8'd0);
            checks++;
            if (obs_dato !== 8'(ed) || obs_lat !== el || obs_err !== 1'b0) begin
                errors++;
                $display("FAIL abort_read%0d: got dato=%0d lat=%0d err=%b, required %0d/%0d/0",
                         i, obs_dato, obs_lat, obs_err, ed, el);
            end
        end
    endtask

    task automatic test_random;
        int ed, ee, el, en;
        int op, dir, len, dato;
        for (int n = 0; n < 30; n++) begin
            op   = int'($urandom_range(0, 3));
            dir  = int'($urandom_range(0, 12));
            len  = int'($urandom_range(0, 5));
            dato = int'($urandom_range(0, 255));
            model_cmd(op, dir, dato, len, ed, ee, el, en);
            do_cmd(2'(op), 8'(dir), 8'(dato), 8'(len));
            checks++;
            if (obs_dato !== 8'(ed) || obs_err !== 1'(ee) || obs_lat !== el ||
                obs_en_cnt !== en || obs_after !== 1'b0) begin
                errors++;
                $display("FAIL rand_%0d op=%0d dir=%0d len=%0d: got dato=%0d err=%b lat=%0d strobes=%0d after=%b, required %0d/%0d/%0d/%0d/0",
                         n, op, dir, len, obs_dato, obs_err, obs_lat, obs_en_cnt, obs_after,
                         ed, ee, el, en);
            end
        end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (ram[i] !== shadow[i]) begin
                errors++;
                $display("FAIL rand_ram[%0d]: got %0d, required %0d", i, ram[i], shadow[i]);
            end
        end
    endtask

`ifdef RAMINI_READBACK_EN
    task automatic test_readback;
        int ed, ee, el, en;
        corrupt = 1'b1;
        model_cmd(1, 2, 8'h3C, 0, ed, ee, el, en);
        do_cmd(2'b01, 8'd2, 8'h3C, 8'd0);
        checks++;
        if (obs_err !== 1'b1 || obs_lat !== el) begin
            errors++;
            $display("FAIL verify_dir2: got err=%b lat=%0d, required 1/%0d", obs_err, obs_lat, el);
        end
        model_cmd(1, 4, 8'hC3, 0, ed, ee, el, en);
        do_cmd(2'b01, 8'd4, 8'hC3, 8'd0);
        checks++;
        if (obs_err !== 1'b0 || obs_lat !== el) begin
            errors++;
            $display("FAIL verify_dir4: got err=%b lat=%0d, required 0/%0d", obs_err, obs_lat, el);
        end
        model_cmd(2, 1, 8'h11, 3, ed, ee, el, en);
        do_cmd(2'b10, 8'd1, 8'h11, 8'd3);
        checks++;
        if (obs_err !== 1'b1 || obs_lat !== el) begin
            errors++;
            $display("FAIL verify_fill_sticky: got err=%b lat=%0d, required 1/%0d",
                     obs_err, obs_lat, el);
        end
        corrupt = 1'b0;
        model_cmd(2, 6, 8'h22, 2, ed, ee, el, en);
        do_cmd(2'b10, 8'd6, 8'h22, 8'd2);
        checks++;
        if (obs_err !== 1'b0 || obs_lat !== el) begin
            errors++;
            $display("FAIL verify_fill_clean: got err=%b lat=%0d, required 0/%0d",
                     obs_err, obs_lat, el);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_checksum();
        test_write();
        test_range();
        test_reset_abort();
`ifdef RAMINI_READBACK_EN
        test_readback();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
